frame_sequencer: RTL and testbench

Frame-level controller above the sensor state machine. It starts captures on host request, holds the sensor in reset between frames, and counts and tags the row-readout strobes. It enforces single-shot or continuous capture with a frame limit, and watches for overruns and hung frames. Sits between the host/control interface and the sensor state machine; drives the sensor's `RESET` and consumes its `NEW_ROW` and `FRAME_FINISHED` outputs.

---
 rtl/frame_sequencer_pkg.sv | 24 ++
 rtl/frame_sequencer_counter.sv | 21 ++
 rtl/frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared sensor configuration: array geometry, frame sequencer defaults
// and the sequencer state encoding.
package PixelSensorConfig;

  localparam int PIXEL_ARRAY_HEIGHT = 480;

  localparam int DEFAULT_ARM_CYCLES     = 2;
  localparam int DEFAULT_GAP_CYCLES     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    GAP,
    FAULT
  } seq_state_t;

  // Phase timer width: wide enough to reach TIMEOUT_CYCLES-1 with a spare bit
  function automatic int timer_width(input int timeout_cycles);
    return $clog2(timeout_cycles) + 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_counter.sv
// Saturating up-counter with synchronous clear, used as a phase timer.
module Counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLEAR,
  input  logic             ENABLE,
  output logic [WIDTH-1:0] COUNT
);

  // Count while enabled, hold at all-ones so the value never wraps
  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      COUNT <= '0;
    end else if (ENABLE && (COUNT != '1)) begin
      COUNT <= COUNT + WIDTH'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame-level controller above the sensor state machine: arms the sensor,
// tags row strobes, counts frames and watches for overruns and hung frames.
module frame_sequencer
  import PixelSensorConfig::*;
#(
  parameter int ROWS           = PIXEL_ARRAY_HEIGHT,
  parameter int ARM_CYCLES     = DEFAULT_ARM_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic                    CONTINUOUS,
  input  logic [7:0]              FRAME_LIMIT,
  input  logic                    READ_READY,
  input  logic                    SENSOR_NEW_ROW,
  input  logic                    SENSOR_FRAME_FINISHED,
  output logic                    SENSOR_RESET,
  output logic                    BUSY,
  output logic                    ROW_VALID,
  output logic [$clog2(ROWS)-1:0] ROW_INDEX,
  output logic                    FRAME_DONE,
  output logic [7:0]              FRAME_NUMBER,
  output logic                    OVERRUN,
  output logic                    TIMEOUT
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam int IW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

  seq_state_t    state;
  logic [TW-1:0] timer;
  logic [CW-1:0] row_count;
  logic          continuous_latched;
  logic [7:0]    limit_latched;

  logic       in_active;
  logic       start_hit;
  logic       abort_hit;
  logic       arm_done;
  logic       gap_done;
  logic       frame_end;
  logic       run_expired;
  logic       state_change;
  logic [7:0] next_frame;
  logic       capture_over;

  assign in_active    = (state == ARM) || (state == RUN) || (state == GAP);
  assign start_hit    = (state == IDLE) && START;
  assign abort_hit    = ABORT && (in_active || (state == FAULT));
  assign arm_done     = (state == ARM) && (timer == TW'(ARM_CYCLES - 1));
  assign gap_done     = (state == GAP) && (timer == TW'(GAP_CYCLES - 1));
  assign frame_end    = (state == RUN) && SENSOR_FRAME_FINISHED;
  assign run_expired  = (state == RUN) && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign state_change = start_hit | abort_hit | arm_done | gap_done | frame_end | run_expired;
  assign next_frame   = FRAME_NUMBER + 8'd1;
  assign capture_over = !continuous_latched ||
                        ((limit_latched != 8'd0) && (next_frame == limit_latched));

  // Phase timer restarts from zero on the first cycle of every state
  Counter #(
    .WIDTH(TW)
  ) u_phase_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .CLEAR (state_change),
    .ENABLE(in_active),
    .COUNT (timer)
  );

  // Sequencer FSM with registered outputs, row tagging and sticky flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state              <= IDLE;
      SENSOR_RESET       <= 1'b1;
      BUSY               <= 1'b0;
      ROW_VALID          <= 1'b0;
      ROW_INDEX          <= '0;
      FRAME_DONE         <= 1'b0;
      FRAME_NUMBER       <= 8'd0;
      OVERRUN            <= 1'b0;
      TIMEOUT            <= 1'b0;
      row_count          <= '0;
      continuous_latched <= 1'b0;
      limit_latched      <= 8'd0;
    end else begin
      ROW_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          SENSOR_RESET <= 1'b1;
          BUSY         <= 1'b0;
          if (START) begin
            continuous_latched <= CONTINUOUS;
            limit_latched      <= FRAME_LIMIT;
            FRAME_NUMBER       <= 8'd0;
            OVERRUN            <= 1'b0;
            TIMEOUT            <= 1'b0;
            row_count          <= '0;
            BUSY               <= 1'b1;
            state              <= ARM;
          end
        end
        ARM: begin
          row_count <= '0;
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else if (arm_done) begin
            SENSOR_RESET <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (ABORT) begin
            SENSOR_RESET <= 1'b1;
            BUSY         <= 1'b0;
            state        <= IDLE;
          end else begin
            if (SENSOR_NEW_ROW) begin
              if (READ_READY && (row_count < ROWS_C)) begin
                ROW_VALID <= 1'b1;
                ROW_INDEX <= row_count[IW-1:0];
              end else begin
                OVERRUN <= 1'b1;
              end
              if (row_count != ROWS_C) begin
                row_count <= row_count + CW'(1);
              end
            end
            if (SENSOR_FRAME_FINISHED) begin
              FRAME_DONE   <= 1'b1;
              FRAME_NUMBER <= next_frame;
              SENSOR_RESET <= 1'b1;
              if (capture_over) begin
                BUSY  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= GAP;
              end
            end else if (run_expired) begin
              TIMEOUT      <= 1'b1;
              SENSOR_RESET <= 1'b1;
              BUSY         <= 1'b0;
              state        <= FAULT;
            end
          end
        end
        GAP: begin
          row_count <= '0;
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else if (gap_done) begin
            SENSOR_RESET <= 1'b0;
            state        <= RUN;
          end
        end
        FAULT: begin
          SENSOR_RESET <= 1'b1;
          BUSY         <= 1'b0;
          if (ABORT) begin
            TIMEOUT <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          SENSOR_RESET <= 1'b1;
          BUSY         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a 4-row sensor model.
module tb_frame_sequencer;

  localparam int ROWS = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       CONTINUOUS = 1'b0;
  logic [7:0] FRAME_LIMIT = 8'd0;
  logic       READ_READY = 1'b1;
  logic       SENSOR_NEW_ROW = 1'b0;
  logic       SENSOR_FRAME_FINISHED = 1'b0;
  logic       SENSOR_RESET;
  logic       BUSY;
  logic       ROW_VALID;
  logic [1:0] ROW_INDEX;
  logic       FRAME_DONE;
  logic [7:0] FRAME_NUMBER;
  logic       OVERRUN;
  logic       TIMEOUT;

  int assert_count = 0;
  int fail_count = 0;

  frame_sequencer #(
    .ROWS          (ROWS),
    .ARM_CYCLES    (2),
    .GAP_CYCLES    (16),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .START                (START),
    .ABORT                (ABORT),
    .CONTINUOUS           (CONTINUOUS),
    .FRAME_LIMIT          (FRAME_LIMIT),
    .READ_READY           (READ_READY),
    .SENSOR_NEW_ROW       (SENSOR_NEW_ROW),
    .SENSOR_FRAME_FINISHED(SENSOR_FRAME_FINISHED),
    .SENSOR_RESET         (SENSOR_RESET),
    .BUSY                 (BUSY),
    .ROW_VALID            (ROW_VALID),
    .ROW_INDEX            (ROW_INDEX),
    .FRAME_DONE           (FRAME_DONE),
    .FRAME_NUMBER         (FRAME_NUMBER),
    .OVERRUN              (OVERRUN),
    .TIMEOUT              (TIMEOUT)
  );

  // 100 MHz clock
  always #5 CLK = ~CLK;

  // Hard stop in case the sequence stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive sensor/control inputs for one edge, then return them to idle
  task automatic applyStimulus(input logic new_row, input logic ready,
                               input logic finished, input logic abort);
    SENSOR_NEW_ROW        = new_row;
    READ_READY            = ready;
    SENSOR_FRAME_FINISHED = finished;
    ABORT                 = abort;
    tick();
    SENSOR_NEW_ROW        = 1'b0;
    READ_READY            = 1'b1;
    SENSOR_FRAME_FINISHED = 1'b0;
    ABORT                 = 1'b0;
  endtask

  // START at edge 0; ARM holds reset for cycles 1-2, RUN begins at cycle 3
  task automatic startCapture(input logic cont, input logic [7:0] limit);
    START       = 1'b1;
    CONTINUOUS  = cont;
    FRAME_LIMIT = limit;
    tick();
    START = 1'b0;
    checkOutput("arm_busy", BUSY, 1);
    checkOutput("arm_sensor_reset_c1", SENSOR_RESET, 1);
    checkOutput("start_clears_frame_number", FRAME_NUMBER, 0);
    checkOutput("start_clears_overrun", OVERRUN, 0);
    checkOutput("start_clears_timeout", TIMEOUT, 0);
    tick();
    checkOutput("arm_sensor_reset_c2", SENSOR_RESET, 1);
    tick();
    checkOutput("run_sensor_reset_low", SENSOR_RESET, 0);
    checkOutput("run_busy", BUSY, 1);
  endtask

  task automatic sendRow(input logic ready, input logic exp_valid, input logic [1:0] exp_index);
    applyStimulus(1'b1, ready, 1'b0, 1'b0);
    checkOutput("row_valid", ROW_VALID, exp_valid);
    if (exp_valid) checkOutput("row_index", ROW_INDEX, exp_index);
  endtask

  task automatic finishFrame(input logic [7:0] exp_number, input logic exp_busy);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("frame_done", FRAME_DONE, 1);
    checkOutput("frame_number", FRAME_NUMBER, exp_number);
    checkOutput("frame_done_sensor_reset", SENSOR_RESET, 1);
    checkOutput("frame_done_busy", BUSY, exp_busy);
  endtask

  // Count SENSOR_RESET-high cycles starting with the FRAME_DONE cycle
  task automatic measureGap();
    int n = 1;
    while (n < 64) begin
      tick();
      if (SENSOR_RESET) n++;
      else break;
    end
    checkOutput("gap_length", n, 16);
    checkOutput("gap_back_to_run", SENSOR_RESET, 0);
  endtask

  initial begin
    // Reset values
    RESET = 1'b1;
    tick();
    tick();
    checkOutput("reset_sensor_reset", SENSOR_RESET, 1);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_row_valid", ROW_VALID, 0);
    checkOutput("reset_frame_done", FRAME_DONE, 0);
    checkOutput("reset_frame_number", FRAME_NUMBER, 0);
    checkOutput("reset_overrun", OVERRUN, 0);
    checkOutput("reset_timeout", TIMEOUT, 0);
    RESET = 1'b0;
    tick();

    $display("[TB] single-shot capture");
    startCapture(1'b0, 8'd0);
    tick();
    for (int r = 0; r < 4; r++) begin
      sendRow(1'b1, 1'b1, 2'(r));
      checkOutput("run_sensor_reset_rows", SENSOR_RESET, 0);
      tick();
    end
    finishFrame(8'd1, 1'b0);
    tick();
    checkOutput("single_done_pulse_ends", FRAME_DONE, 0);
    checkOutput("single_idle_busy", BUSY, 0);
    checkOutput("single_no_overrun", OVERRUN, 0);

    $display("[TB] continuous capture, limit 3");
    startCapture(1'b1, 8'd3);
    for (int f = 1; f <= 3; f++) begin
      sendRow(1'b1, 1'b1, 2'd0);
      finishFrame(8'(f), f < 3);
      if (f < 3) measureGap();
    end
    tick();
    checkOutput("limit3_idle_busy", BUSY, 0);
    checkOutput("limit3_frame_number", FRAME_NUMBER, 3);

    $display("[TB] continuous capture, unlimited, abort after 5");
    startCapture(1'b1, 8'd0);
    for (int f = 1; f <= 5; f++) begin
      finishFrame(8'(f), 1'b1);
      measureGap();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("abort_busy", BUSY, 0);
    checkOutput("abort_sensor_reset", SENSOR_RESET, 1);
    checkOutput("abort_frame_number", FRAME_NUMBER, 5);

    $display("[TB] overrun on dropped row");
    startCapture(1'b0, 8'd0);
    sendRow(1'b1, 1'b1, 2'd0);
    sendRow(1'b0, 1'b0, 2'd0);
    checkOutput("overrun_not_ready", OVERRUN, 1);
    sendRow(1'b1, 1'b1, 2'd2);
    sendRow(1'b1, 1'b1, 2'd3);
    finishFrame(8'd1, 1'b0);
    checkOutput("overrun_sticky", OVERRUN, 1);

    $display("[TB] overrun on fifth row");
    startCapture(1'b0, 8'd0);
    for (int r = 0; r < 4; r++) sendRow(1'b1, 1'b1, 2'(r));
    checkOutput("four_rows_no_overrun", OVERRUN, 0);
    sendRow(1'b1, 1'b0, 2'd0);
    checkOutput("overrun_fifth_row", OVERRUN, 1);
    finishFrame(8'd1, 1'b0);

    $display("[TB] collisions");
    startCapture(1'b0, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("collide_row_valid", ROW_VALID, 1);
    checkOutput("collide_row_index", ROW_INDEX, 0);
    checkOutput("collide_frame_done", FRAME_DONE, 1);
    checkOutput("collide_frame_number", FRAME_NUMBER, 1);
    startCapture(1'b1, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("abort_beats_finish_done", FRAME_DONE, 0);
    checkOutput("abort_beats_finish_number", FRAME_NUMBER, 0);
    checkOutput("abort_beats_finish_busy", BUSY, 0);

    $display("[TB] finish on timer expiry");
    startCapture(1'b0, 8'd0);
    repeat (1023) tick();
    checkOutput("expiry_still_running", BUSY, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("expiry_finish_done", FRAME_DONE, 1);
    checkOutput("expiry_finish_no_timeout", TIMEOUT, 0);

    $display("[TB] timeout");
    startCapture(1'b0, 8'd0);
    repeat (1023) tick();
    checkOutput("pre_timeout_flag", TIMEOUT, 0);
    checkOutput("pre_timeout_busy", BUSY, 1);
    tick();
    checkOutput("timeout_flag", TIMEOUT, 1);
    checkOutput("timeout_busy", BUSY, 0);
    checkOutput("timeout_sensor_reset", SENSOR_RESET, 1);
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    checkOutput("fault_ignores_start_busy", BUSY, 0);
    checkOutput("fault_ignores_start_timeout", TIMEOUT, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("fault_abort_clears_timeout", TIMEOUT, 0);
    checkOutput("fault_abort_busy", BUSY, 0);

    $display("[TB] reset mid-run");
    startCapture(1'b1, 8'd0);
    finishFrame(8'd1, 1'b1);
    measureGap();
    sendRow(1'b0, 1'b0, 2'd0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkOutput("midreset_sensor_reset", SENSOR_RESET, 1);
    checkOutput("midreset_busy", BUSY, 0);
    checkOutput("midreset_overrun", OVERRUN, 0);
    checkOutput("midreset_frame_number", FRAME_NUMBER, 0);
    startCapture(1'b0, 8'd0);
    sendRow(1'b1, 1'b1, 2'd0);
    finishFrame(8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
